pls_meas: RTL and testbench
===========================

Name: pls_meas

Overview:
- Pulse measurement block; the receiving end of the pulse generator's pls/sync_out pair.
- Samples an asynchronous pulse train and measures, in clk cycles, its period, its high time and its phase relative to an incoming sync strobe.
- Reports each completed period and declares lock once the waveform is stable.
- Used for loopback self-test of the generator and for monitoring externally supplied pulse trains.

Parameters:
P_CNT_W, 16, width of all measurement counters and result ports
P_TIMEOUT_CNT, 1000, cycles since the last rising edge after which the input is declared dead (must be < 2^P_CNT_W-1)
P_LOCK_N, 4, consecutive matching periods required to assert locked
P_TOL, 1, max |difference| in counts between consecutive period or high measurements that still counts as "matching"

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
pls_in  input  1  pulse waveform to measure; asynchronous to clk
sync_in  input  1  phase reference strobe (one clk wide, e.g. generator sync_out); asynchronous
period_cnt  output  P_CNT_W  cycles between the last two rising edges
high_cnt  output  P_CNT_W  cycles pls was high within that period
phase_cnt  output  P_CNT_W  cycles from sync to rising edge, minus 1
phase_ok  output  1  a sync has been seen since reset/timeout, so phase_cnt is meaningful
meas_valid  output  1  one-cycle strobe: period/high/phase outputs updated
locked  output  1  stable waveform detected
err_timeout  output  1  one-cycle strobe: no rising edge for P_TIMEOUT_CNT cycles

Behaviour:
- pls_in and sync_in each pass through a 2-FF synchronizer, giving pls_s and sync_s with equal latency, so phase alignment is preserved.
- Edge detector: rise = pls_s & ~pls_d; fall = ~pls_s & pls_d. pls_d resets to 1, so a pls_in held high through reset is never a false rise.
- Measurement definitions (cycle indices of the synchronized signals):
  - period = index(rise_n) - index(rise_n-1)
  - high = index(fall) - index(rise_n-1)
  - phase = index(rise_n) - index(last sync_s) - 1, which equals the generator's PHASE_CNT directly
- FSM:
  - S_IDLE: wait for a rise, then go to S_ARM.
  - S_ARM: measure the first period; the next rise goes to S_RUN with no meas_valid.
  - S_RUN: every rise updates the outputs and pulses meas_valid.
  - Timeout from S_ARM or S_RUN goes to S_IDLE.
- Latency: meas_valid is high 3 clk cycles after the first clk edge that samples pls_in=1 (2 sync + 1 registered output).
- All counters saturate at 2^P_CNT_W-1; they never wrap.
- Timeout: the period counter reaching P_TIMEOUT_CNT with no rise causes:
  - err_timeout pulses for 1 cycle
  - locked clears, phase_ok clears
  - FSM enters S_IDLE
  - result ports hold their last values
- Lock:
  - A match counter increments on each meas_valid where |period - prev period| <= P_TOL and |high - prev high| <= P_TOL; otherwise it clears to 0.
  - locked=1 when the counter reaches P_LOCK_N, and stays 1 while matches continue.
  - A single mismatch clears locked in the same cycle meas_valid reports the mismatch.
- Phase:
  - The phase counter clears on sync_s and increments otherwise (saturating).
  - If sync_s and rise occur in the same cycle, the rise captures the pre-clear value (steady state: period-1).
  - Before any sync: phase_ok=0 and phase_cnt=0.
- Falls in S_IDLE are ignored. A rise with no intervening fall cannot occur. high_cnt >= 1 always.
- Reset (asynchronous, any time): all outputs 0, FSM S_IDLE, match counter 0, synchronizers 0 (pls_d=1). Operation restarts cleanly after release.

Decomposition:
- Shared package pgen_pkg holds:
  - the FSM state typedef (S_IDLE, S_ARM, S_RUN)
  - the default P_CNT_W constant
  - a function computing expected period/high/phase counts from frequency, duty and phase parameters, used by both the generator and this block's benches
- One sub-module, pls_sync_edge: 2-FF synchronizer plus rise/fall detection, instantiated once for pls_in and once (rise unused) for sync_in.

Test Plan:
- Generator defaults (20MHz/2MHz, 50%, 0deg) looped back -> period_cnt=10, high_cnt=5, phase_cnt=0, phase_ok=1; locked asserts on the 4th matching meas_valid.
- Generator at 90deg, 30% duty -> period_cnt=10, high_cnt=3, phase_cnt=2; locked=1.
- Locked at period 10, pls_in stopped low -> err_timeout pulses once 1000 cycles after the last rise; locked=0; outputs hold 10/5.
- Period switched 10->20 while locked -> first meas_valid reports 20 with locked=0; re-lock after 4 further matching periods.
- pls_in high across reset release, sync_in never driven -> no meas_valid before a genuine low->high transition; phase_ok=0, phase_cnt=0 throughout.
- rst_n asserted mid-high-pulse while locked -> all outputs 0 immediately; after release, first meas_valid only after two full new rises.

Source files
------------

// File: rtl/pgen_pkg.sv
// Definitions shared by the pulse generator and the pulse measurement block:
// measurement FSM states, default counter width and an expected-count helper.
package pgen_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARM  = 2'd1,
    S_RUN  = 2'd2
  } meas_state_e;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
    logic [CNT_W-1:0] phase;
  } pls_counts_t;

  // Counts in clk cycles for a waveform of pls_hz derived from clk_hz; fractions truncate.
  function automatic pls_counts_t calc_counts(input int unsigned clk_hz,
                                              input int unsigned pls_hz,
                                              input int unsigned duty_pct,
                                              input int unsigned phase_deg);
    pls_counts_t r_res;
    int unsigned per;
    per          = clk_hz / pls_hz;
    r_res.period = CNT_W'(per);
    r_res.high   = CNT_W'((per * duty_pct) / 100);
    r_res.phase  = CNT_W'((per * phase_deg) / 360);
    return r_res;
  endfunction

endpackage

// File: rtl/pls_sync_edge.sv
// Two-flop synchronizer with rise/fall detection on the synchronized level.
// Edges are suppressed until the synchronizer has refilled after reset.
module pls_sync_edge #(
  parameter logic P_D_RST = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic       r_s1;
  logic       r_s2;
  logic       r_d;
  logic [1:0] r_fill;

  // r_d holds its reset value until r_s2 carries a real sample, so a level
  // already high at reset release never shows up as a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_d    <= P_D_RST;
      r_fill <= 2'b00;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_fill <= {r_fill[0], 1'b1};
      if (r_fill[1]) begin
        r_d <= r_s2;
      end
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_fill[1] & r_s2 & ~r_d;
  assign o_fall  = r_fill[1] & ~r_s2 & r_d;

endmodule

// File: rtl/pls_meas.sv
// Pulse measurement: period, high time and sync-relative phase of an
// asynchronous pulse train, with lock detection and dead-input timeout.
//
// state  | meaning
// S_IDLE | no live input; waiting for the first rising edge
// S_ARM  | first period being measured, never reported
// S_RUN  | every rising edge reports period/high/phase
module pls_meas
  import pgen_pkg::*;
#(
  parameter int P_CNT_W       = CNT_W,
  parameter int P_TIMEOUT_CNT = 1000,
  parameter int P_LOCK_N      = 4,
  parameter int P_TOL         = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pls_in,
  input  logic               sync_in,
  output logic [P_CNT_W-1:0] period_cnt,
  output logic [P_CNT_W-1:0] high_cnt,
  output logic [P_CNT_W-1:0] phase_cnt,
  output logic               phase_ok,
  output logic               meas_valid,
  output logic               locked,
  output logic               err_timeout
);

  localparam int                 L_MW   = $clog2(P_LOCK_N + 1);
  localparam logic [P_CNT_W-1:0] L_MAX  = '1;
  localparam logic [P_CNT_W-1:0] L_ONE  = P_CNT_W'(1);
  localparam logic [P_CNT_W-1:0] L_TMO  = P_CNT_W'(P_TIMEOUT_CNT);
  localparam logic [P_CNT_W-1:0] L_TOL  = P_CNT_W'(P_TOL);
  localparam logic [L_MW-1:0]    L_LOCK = L_MW'(P_LOCK_N);

  logic w_pls_s, w_rise, w_fall;
  logic w_sync_s, w_sync_rise, w_sync_fall;
  logic w_unused;

  meas_state_e r_state, w_state_nxt;
  logic        w_meas, w_load_prev, w_timeout, w_tmo_hit;

  logic [P_CNT_W-1:0] r_per_cnt, r_high_tmp, r_ph_cnt;
  logic               r_sync_seen;
  logic [P_CNT_W-1:0] r_prev_per, r_prev_high;
  logic [P_CNT_W-1:0] w_per_diff, w_high_diff;
  logic               w_per_match, w_high_match;
  logic [L_MW-1:0]    r_match, w_match_inc;

  logic [P_CNT_W-1:0] r_period_cnt, r_high_cnt, r_phase_cnt;
  logic               r_phase_ok, r_meas_valid, r_locked, r_err_timeout;

  pls_sync_edge #(.P_D_RST(1'b1)) u_pls_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (pls_in),
    .o_level (w_pls_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Same latency as the pulse path, so sync-to-rise distance is preserved.
  pls_sync_edge #(.P_D_RST(1'b0)) u_sync_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (sync_in),
    .o_level (w_sync_s),
    .o_rise  (w_sync_rise),
    .o_fall  (w_sync_fall)
  );

  assign w_unused = &{1'b0, w_pls_s, w_sync_rise, w_sync_fall};

  assign w_tmo_hit = (r_per_cnt >= L_TMO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_meas      = 1'b0;
    w_load_prev = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_ARM;
        end
      end
      S_ARM: begin
        if (w_rise) begin
          w_state_nxt = S_RUN;
          w_load_prev = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      S_RUN: begin
        if (w_rise) begin
          w_meas = 1'b1;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Period counter reads 1 in the cycle after a rise, so at the next rise it
  // holds the rise-to-rise distance; at a fall it holds the high time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_per_cnt   <= '0;
      r_high_tmp  <= '0;
      r_ph_cnt    <= '0;
      r_sync_seen <= 1'b0;
    end else begin
      if (w_rise) begin
        r_per_cnt <= L_ONE;
      end else if (r_state != S_IDLE && r_per_cnt != L_MAX) begin
        r_per_cnt <= r_per_cnt + 1'b1;
      end
      if (w_fall && r_state != S_IDLE) begin
        r_high_tmp <= r_per_cnt;
      end
      if (w_sync_s) begin
        r_ph_cnt <= '0;
      end else if (r_ph_cnt != L_MAX) begin
        r_ph_cnt <= r_ph_cnt + 1'b1;
      end
      if (w_timeout) begin
        r_sync_seen <= 1'b0;
      end else if (w_sync_s) begin
        r_sync_seen <= 1'b1;
      end
    end
  end

  assign w_per_diff   = (r_per_cnt >= r_prev_per) ? (r_per_cnt - r_prev_per)
                                                  : (r_prev_per - r_per_cnt);
  assign w_high_diff  = (r_high_tmp >= r_prev_high) ? (r_high_tmp - r_prev_high)
                                                    : (r_prev_high - r_high_tmp);
  assign w_per_match  = (w_per_diff <= L_TOL);
  assign w_high_match = (w_high_diff <= L_TOL);
  assign w_match_inc  = (r_match == L_LOCK) ? r_match : r_match + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_per    <= '0;
      r_prev_high   <= '0;
      r_match       <= '0;
      r_period_cnt  <= '0;
      r_high_cnt    <= '0;
      r_phase_cnt   <= '0;
      r_phase_ok    <= 1'b0;
      r_meas_valid  <= 1'b0;
      r_locked      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_meas_valid  <= 1'b0;
      r_err_timeout <= 1'b0;
      if (w_load_prev || w_meas) begin
        r_prev_per  <= r_per_cnt;
        r_prev_high <= r_high_tmp;
      end
      if (w_meas) begin
        r_period_cnt <= r_per_cnt;
        r_high_cnt   <= r_high_tmp;
        r_phase_cnt  <= r_sync_seen ? r_ph_cnt : '0;
        r_phase_ok   <= r_sync_seen;
        r_meas_valid <= 1'b1;
        if (w_per_match && w_high_match) begin
          r_match  <= w_match_inc;
          r_locked <= (w_match_inc == L_LOCK);
        end else begin
          r_match  <= '0;
          r_locked <= 1'b0;
        end
      end
      // Result ports deliberately keep their last values across a timeout.
      if (w_timeout) begin
        r_err_timeout <= 1'b1;
        r_locked      <= 1'b0;
        r_phase_ok    <= 1'b0;
        r_match       <= '0;
      end
    end
  end

  assign period_cnt  = r_period_cnt;
  assign high_cnt    = r_high_cnt;
  assign phase_cnt   = r_phase_cnt;
  assign phase_ok    = r_phase_ok;
  assign meas_valid  = r_meas_valid;
  assign locked      = r_locked;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_pls_meas.sv
// Bench for pls_meas: table of looped-back waveforms plus hand sequences for
// timeout, reset mid-pulse, high-through-reset and lock tolerance edges.
module tb_pls_meas;
  import pgen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pls_in = 1'b0;
  logic        sync_in = 1'b0;
  logic [15:0] period_cnt, high_cnt, phase_cnt;
  logic        phase_ok, meas_valid, locked, err_timeout;

  always #5 clk = ~clk;

  pls_meas #(
    .P_CNT_W       (16),
    .P_TIMEOUT_CNT (1000),
    .P_LOCK_N      (4),
    .P_TOL         (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pls_in      (pls_in),
    .sync_in     (sync_in),
    .period_cnt  (period_cnt),
    .high_cnt    (high_cnt),
    .phase_cnt   (phase_cnt),
    .phase_ok    (phase_ok),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .err_timeout (err_timeout)
  );

  typedef struct {
    logic [15:0] per;
    logic [15:0] hi;
    logic [15:0] ph;
    logic        ok;
    logic        lk;
    int          cyc;
  } mv_rec_t;

  mv_rec_t mv_q[$];
  mv_rec_t mon_rec;
  int      cyc = 0;
  int      to_n = 0;
  int      to_cyc = -1;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (meas_valid === 1'b1) begin
      mon_rec.per = period_cnt;
      mon_rec.hi  = high_cnt;
      mon_rec.ph  = phase_cnt;
      mon_rec.ok  = phase_ok;
      mon_rec.lk  = locked;
      mon_rec.cyc = cyc;
      mv_q.push_back(mon_rec);
    end
    if (err_timeout === 1'b1) begin
      to_n   = to_n + 1;
      to_cyc = cyc;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic mv_rec_t mv_at(input int idx);
    mv_rec_t r;
    r.per = '1; r.hi = '1; r.ph = '1; r.ok = 1'bx; r.lk = 1'bx; r.cyc = -1;
    if (idx >= 0 && idx < mv_q.size()) r = mv_q[idx];
    return r;
  endfunction

  task automatic chk_zero(input string pfx);
    chk({pfx, "_period"}, 32'(period_cnt), 0);
    chk({pfx, "_high"},   32'(high_cnt), 0);
    chk({pfx, "_phase"},  32'(phase_cnt), 0);
    chk({pfx, "_ok"},     32'(phase_ok), 0);
    chk({pfx, "_valid"},  32'(meas_valid), 0);
    chk({pfx, "_locked"}, 32'(locked), 0);
    chk({pfx, "_tmo"},    32'(err_timeout), 0);
  endtask

  // Rise at c==0 of each period; sync strobe placed phase+1 cycles before it.
  task automatic drive(input int per, input int hi, input int ph, input bit sync_en, input int n);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        pls_in  = (c < hi);
        sync_in = sync_en && (c == ((per - ph - 1) % per));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pls_in  = 1'b0;
      sync_in = 1'b0;
    end
  endtask

  typedef struct {
    int unsigned f_hz;
    int unsigned duty;
    int unsigned deg;
    bit          sync_en;
    int          n;
    int          exp_mv;
    int          exp_per;
    int          exp_hi;
    int          exp_ph;
    bit          exp_ok;
    bit          exp_lk;
  } vec_t;

  vec_t        vecs[4];
  string       vname[4];
  int          vbase[4];
  pls_counts_t cnts;
  int          base, last_mv, to0, bad;

  initial begin
    //          f_hz        duty deg sync n  mv per hi ph ok lk
    vecs[0] = '{2_000_000,  50,  0,  1,   8, 6, 10, 5,  0, 1, 1}; vname[0] = "dflt";
    vecs[1] = '{2_000_000,  30,  90, 1,   8, 8, 10, 3,  2, 1, 1}; vname[1] = "ph90";
    vecs[2] = '{1_000_000,  50,  0,  1,   6, 6, 20, 10, 0, 1, 1}; vname[2] = "p20";
    vecs[3] = '{2_000_000,  50,  0,  1,   6, 6, 10, 5,  0, 1, 1}; vname[3] = "back10";

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    idle(5);

    for (int i = 0; i < 4; i++) begin
      cnts     = calc_counts(20_000_000, vecs[i].f_hz, vecs[i].duty, vecs[i].deg);
      vbase[i] = mv_q.size();
      drive(int'(cnts.period), int'(cnts.high), int'(cnts.phase), vecs[i].sync_en, vecs[i].n);
      chk({vname[i], "_mv"},     32'(mv_q.size() - vbase[i]), 32'(vecs[i].exp_mv));
      chk({vname[i], "_period"}, 32'(period_cnt), 32'(vecs[i].exp_per));
      chk({vname[i], "_high"},   32'(high_cnt), 32'(vecs[i].exp_hi));
      chk({vname[i], "_phase"},  32'(phase_cnt), 32'(vecs[i].exp_ph));
      chk({vname[i], "_ok"},     32'(phase_ok), 32'(vecs[i].exp_ok));
      chk({vname[i], "_locked"}, 32'(locked), 32'(vecs[i].exp_lk));
    end

    // Lock asserts exactly on the 4th matching report.
    chk("dflt_lk_mv3", 32'(mv_at(vbase[0] + 2).lk), 0);
    chk("dflt_lk_mv4", 32'(mv_at(vbase[0] + 3).lk), 1);
    chk("dflt_ph_mv1", 32'(mv_at(vbase[0]).ph), 0);
    chk("dflt_ok_mv1", 32'(mv_at(vbase[0]).ok), 1);
    // Period 10->20 while locked: first 20 report drops lock, 4 more relock.
    chk("p20_first_per", 32'(mv_at(vbase[2] + 1).per), 20);
    chk("p20_first_lk",  32'(mv_at(vbase[2] + 1).lk), 0);
    chk("p20_lk_m3",     32'(mv_at(vbase[2] + 4).lk), 0);
    chk("p20_lk_m4",     32'(mv_at(vbase[2] + 5).lk), 1);

    // Timeout: input stops low while locked at 10/5.
    last_mv = (mv_q.size() > 0) ? mv_q[mv_q.size() - 1].cyc : 0;
    to0     = to_n;
    idle(1100);
    chk("tmo_pulses", 32'(to_n - to0), 1);
    chk("tmo_delay",  32'(to_cyc - last_mv), 1000);
    chk("tmo_locked", 32'(locked), 0);
    chk("tmo_ok",     32'(phase_ok), 0);
    chk("tmo_period", 32'(period_cnt), 10);
    chk("tmo_high",   32'(high_cnt), 5);

    // Relock from idle, then reset in the middle of a high pulse.
    base = mv_q.size();
    drive(10, 5, 0, 1'b1, 8);
    chk("relock_mv", 32'(mv_q.size() - base), 6);
    chk("relock_locked", 32'(locked), 1);
    @(negedge clk); pls_in = 1'b1; sync_in = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pls_in = 1'b0;
    repeat (5) @(negedge clk);
    base = mv_q.size();
    drive(10, 5, 0, 1'b1, 2);
    chk("midrst_2rises_mv", 32'(mv_q.size() - base), 0);
    drive(10, 5, 0, 1'b1, 1);
    chk("midrst_3rises_mv", 32'(mv_q.size() - base), 1);
    chk("midrst_per", 32'(mv_at(base).per), 10);
    chk("midrst_hi",  32'(mv_at(base).hi), 5);

    // pls_in high through reset release, sync never driven.
    @(negedge clk); rst_n = 1'b0; pls_in = 1'b1; sync_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    base = mv_q.size();
    repeat (20) @(negedge clk);
    chk("hirst_mv", 32'(mv_q.size() - base), 0);
    chk("hirst_ok", 32'(phase_ok), 0);
    chk("hirst_ph", 32'(phase_cnt), 0);
    pls_in = 1'b0;
    repeat (5) @(negedge clk);
    drive(10, 5, 0, 1'b0, 5);
    chk("hirst_run_mv", 32'(mv_q.size() - base), 3);
    chk("hirst_per", 32'(period_cnt), 10);
    bad = 0;
    for (int k = base; k < mv_q.size(); k++) begin
      if (mv_q[k].ok !== 1'b0 || mv_q[k].ph !== 16'd0) bad++;
    end
    chk("hirst_nosync_recs", 32'(bad), 0);

    // Lock tolerance: a 1-count period change keeps lock, 2 counts drops it.
    base = mv_q.size();
    drive(11, 5, 0, 1'b0, 1);
    drive(10, 5, 0, 1'b0, 2);
    drive(12, 5, 0, 1'b0, 1);
    drive(10, 5, 0, 1'b0, 1);
    chk("tol_mv",     32'(mv_q.size() - base), 5);
    chk("tol_lk4",    32'(mv_at(base).lk), 1);
    chk("tol_per11",  32'(mv_at(base + 1).per), 11);
    chk("tol_lk_d1",  32'(mv_at(base + 1).lk), 1);
    chk("tol_per12",  32'(mv_at(base + 4).per), 12);
    chk("tol_lk_d2",  32'(mv_at(base + 4).lk), 0);

    idle(5);
    chk("tmo_total", 32'(to_n), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
